branch_resolve_ctrl: RTL and testbench

- Multicycle controller that sequences branch and jump resolution between the decode stage and the IFU.
- Accepts one control-transfer instruction at a time over a valid/ready handshake and evaluates the condition with its internal compare datapath.
- Returns the result (taken flag, target, link value) to writeback, and issues a PC redirect plus a one-cycle flush to the fetch side on misprediction.
- Keeps branch and mispredict performance counters.

---
 rtl/branch_resolve_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Multicycle controller that resolves one control-transfer instruction at a
// time between decode and the IFU. The instruction is captured in IDLE,
// evaluated from the registered operands in EVAL, and presented in RESP.
// RESP carries a result to writeback and, on a misprediction, also a PC
// redirect plus a one-cycle flush to fetch.
//
// Handshake rule (applies to in_*, out_* and redirect_*):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   A valid, once raised, stays high with stable payload until its transfer.
//   The sender never waits on ready before raising valid.
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   in_valid/in_ready    instruction handshake from decode
//   in_pc, in_imm        instruction PC and sign-extended offset
//   in_rs1, in_rs2       source operands
//   in_branch_type       001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu
//   in_jump              00 branch, 01 jal, 10 jalr, 11 treated as branch
//   in_pred_taken        fetch-side direction prediction
//   out_valid/out_ready  result handshake to writeback
//   out_taken            resolved direction
//   out_target           resolved next PC
//   out_link             pc+4 for the jal/jalr rd write
//   redirect_valid/ready redirect handshake to the IFU (mispredicts only)
//   redirect_pc          restart address, equal to out_target
//   flush                high in the cycle the redirect transfer completes
//   cnt_branch           completed control transfers (wraps)
//   cnt_mispredict       completed mispredictions (wraps)
// -----------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [2:0]       in_branch_type,
  input  logic [1:0]       in_jump,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispredict
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured instruction
  logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q;
  logic [2:0]      btype_q;
  logic [1:0]      jump_q;
  logic            pred_q;

  // Resolution results and per-handshake completion flags
  logic            misp_q;
  logic            out_done_q;
  logic            redir_done_q;

  // FSM control strobes
  logic            idle_ready;
  logic            accept;
  logic            eval;
  logic            out_hs;
  logic            redir_hs;
  logic            complete;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    idle_ready     = 1'b0;
    accept         = 1'b0;
    eval           = 1'b0;
    out_valid      = 1'b0;
    redirect_valid = 1'b0;
    out_hs         = 1'b0;
    redir_hs       = 1'b0;
    flush          = 1'b0;
    complete       = 1'b0;
    case (state_q)
      IDLE: begin
        idle_ready = 1'b1;
        accept     = in_valid;
        if (in_valid) state_d = EVAL;
      end
      EVAL: begin
        eval    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        out_valid      = ~out_done_q;
        redirect_valid = misp_q & ~redir_done_q;
        out_hs         = out_valid & out_ready;
        redir_hs       = redirect_valid & redirect_ready;
        flush          = redir_hs;
        // A correctly predicted transfer has no redirect to wait for.
        complete       = (out_done_q | out_hs) &
                         (~misp_q | redir_done_q | redir_hs);
        if (complete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset holds every output low, including in_ready.
  assign in_ready = idle_ready & ~rst;

  // ---------------------------------------------------------------------------
  // Evaluation datapath, driven only by the captured operands
  // ---------------------------------------------------------------------------
  logic            cond;
  logic            is_jal, is_jalr;
  logic            taken_c;
  logic [XLEN-1:0] br_tgt, jalr_sum, link_c, target_c;

  always_comb begin
    case (btype_q)
      3'b001:  cond = (rs1_q == rs2_q);
      3'b010:  cond = (rs1_q != rs2_q);
      3'b011:  cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b100:  cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b101:  cond = (rs1_q <  rs2_q);
      3'b110:  cond = (rs1_q >= rs2_q);
      default: cond = 1'b0;
    endcase
  end

  assign is_jal   = (jump_q == 2'b01);
  assign is_jalr  = (jump_q == 2'b10);
  assign taken_c  = is_jal | is_jalr | cond;
  assign br_tgt   = pc_q + imm_q;
  assign jalr_sum = rs1_q + imm_q;
  assign link_c   = pc_q + XLEN'(4);
  assign target_c = is_jalr ? (jalr_sum & ~XLEN'(1)) :
                    taken_c ? br_tgt : link_c;

  // ---------------------------------------------------------------------------
  // Datapath registers and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= '0;
      imm_q          <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      btype_q        <= '0;
      jump_q         <= '0;
      pred_q         <= 1'b0;
      misp_q         <= 1'b0;
      out_done_q     <= 1'b0;
      redir_done_q   <= 1'b0;
      out_taken      <= 1'b0;
      out_target     <= '0;
      out_link       <= '0;
      redirect_pc    <= '0;
      cnt_branch     <= '0;
      cnt_mispredict <= '0;
    end else begin
      if (accept) begin
        pc_q    <= in_pc;
        imm_q   <= in_imm;
        rs1_q   <= in_rs1;
        rs2_q   <= in_rs2;
        btype_q <= in_branch_type;
        jump_q  <= in_jump;
        pred_q  <= in_pred_taken;
      end
      if (eval) begin
        out_taken    <= taken_c;
        out_target   <= target_c;
        out_link     <= link_c;
        redirect_pc  <= target_c;
        misp_q       <= (taken_c != pred_q);
        out_done_q   <= 1'b0;
        redir_done_q <= 1'b0;
      end
      if (out_hs)   out_done_q   <= 1'b1;
      if (redir_hs) redir_done_q <= 1'b1;
      if (complete) begin
        cnt_branch <= cnt_branch + CNT_W'(1);
        if (misp_q) cnt_mispredict <= cnt_mispredict + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//
// Directed bench for branch_resolve_ctrl. A transaction-level model derives
// taken/target/link/mispredict from the instruction fields; a negedge
// compare process checks the DUT against it on every cycle, and the test
// sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc, in_imm, in_rs1, in_rs2;
  logic [2:0]       in_branch_type;
  logic [1:0]       in_jump;
  logic             in_pred_taken;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic [XLEN-1:0]  out_link;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_mispredict;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_branch_type (in_branch_type),
    .in_jump        (in_jump),
    .in_pred_taken  (in_pred_taken),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_taken      (out_taken),
    .out_target     (out_target),
    .out_link       (out_link),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .cnt_branch     (cnt_branch),
    .cnt_mispredict (cnt_mispredict)
  );

  // ---------------------------------------------------------------------------
  // Model and scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        misp;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];        // at most one in-flight instruction
  logic [31:0] exp_cnt_branch = 0;
  logic [31:0] exp_cnt_misp   = 0;
  int          flush_seen = 0;

  // Values seen by the driver when the result first appears
  logic        obs_taken;
  logic [31:0] obs_target, obs_link;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural rules for one control transfer.
  function automatic exp_t model(input logic [31:0] pc, imm, rs1, rs2,
                                 input logic [2:0] bt, input logic [1:0] jp,
                                 input logic pred);
    exp_t e;
    logic c;
    c = 1'b0;
    e.link = pc + 32'd4;
    if (jp == 2'b01) begin
      e.taken  = 1'b1;
      e.target = pc + imm;
    end else if (jp == 2'b10) begin
      e.taken  = 1'b1;
      e.target = (rs1 + imm) & 32'hFFFF_FFFE;
    end else begin
      case (bt)
        3'd1: c = (rs1 == rs2);
        3'd2: c = (rs1 != rs2);
        3'd3: c = ($signed(rs1) <  $signed(rs2));
        3'd4: c = ($signed(rs1) >= $signed(rs2));
        3'd5: c = (rs1 <  rs2);
        3'd6: c = (rs1 >= rs2);
        default: c = 1'b0;
      endcase
      e.taken  = c;
      e.target = c ? pc + imm : pc + 32'd4;
    end
    e.misp = (e.taken != pred);
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: every cycle outside reset
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        chk("out_valid_expected", {31'd0, exp_q.size() == 1}, 32'd1);
        if (exp_q.size() == 1) begin
          chk("out_taken",  {31'd0, out_taken}, {31'd0, exp_q[0].taken});
          chk("out_target", out_target, exp_q[0].target);
          chk("out_link",   out_link,   exp_q[0].link);
        end
      end
      if (redirect_valid) begin
        chk("redirect_expected",
            {31'd0, (exp_q.size() == 1) && exp_q[0].misp}, 32'd1);
        if (exp_q.size() == 1) chk("redirect_pc", redirect_pc, exp_q[0].target);
      end
      chk("flush_rule", {31'd0, flush}, {31'd0, redirect_valid & redirect_ready});
      if (flush) flush_seen++;
      chk("cnt_branch",     cnt_branch,     exp_cnt_branch);
      chk("cnt_mispredict", cnt_mispredict, exp_cnt_misp);
      if (exp_q.size() != 0) chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_in(input logic [31:0] pc, imm, rs1, rs2,
                          input logic [2:0] bt, input logic [1:0] jp,
                          input logic pred);
    in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
    in_branch_type = bt; in_jump = jp; in_pred_taken = pred;
    in_valid = 1'b1;
  endtask

  // Scramble the inputs after accept; the DUT must not sample them again.
  task automatic scramble_in();
    in_valid       = 1'b0;
    in_pc          = $urandom;
    in_imm         = $urandom;
    in_rs1         = $urandom;
    in_rs2         = $urandom;
    in_branch_type = 3'($urandom_range(0, 7));
    in_jump        = 2'($urandom_range(0, 3));
    in_pred_taken  = 1'($urandom_range(0, 1));
  endtask

  // Accept one instruction and bring it to the first RESP cycle.
  task automatic accept_txn(input logic [31:0] pc, imm, rs1, rs2,
                            input logic [2:0] bt, input logic [1:0] jp,
                            input logic pred);
    int k;
    exp_t e;
    e = model(pc, imm, rs1, rs2, bt, jp, pred);
    k = 0;
    while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    drive_in(pc, imm, rs1, rs2, bt, jp, pred);
    @(posedge clk);
    exp_q.push_back(e);
    #1 scramble_in();
    chk("eval_no_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_redirect",  {31'd0, redirect_valid}, {31'd0, e.misp});
    obs_taken  = out_taken;
    obs_target = out_target;
    obs_link   = out_link;
  endtask

  // Full transaction; readies rise od_dly / rd_dly cycles into RESP.
  task automatic run_txn(input logic [31:0] pc, imm, rs1, rs2,
                         input logic [2:0] bt, input logic [1:0] jp,
                         input logic pred, input int od_dly, input int rd_dly);
    int  k;
    bit  od, rdn;
    exp_t e;
    e = model(pc, imm, rs1, rs2, bt, jp, pred);
    flush_seen = 0;
    accept_txn(pc, imm, rs1, rs2, bt, jp, pred);
    od  = 1'b0;
    rdn = !e.misp;
    k   = 0;
    while (!(od && rdn) && k < 50) begin
      out_ready      = (k >= od_dly);
      redirect_ready = (k >= rd_dly);
      @(negedge clk);
      if (out_valid && out_ready)           od  = 1'b1;
      if (redirect_valid && redirect_ready) rdn = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    chk("handshake_timeout", {31'd0, od && rdn}, 32'd1);
    out_ready      = 1'b0;
    redirect_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_cnt_branch = exp_cnt_branch + 1;
    if (e.misp) exp_cnt_misp = exp_cnt_misp + 1;
    chk("in_ready_after_resp", {31'd0, in_ready}, 32'd1);
    chk("flush_count", flush_seen, {31'd0, e.misp});
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; redirect_ready = 1'b0;
    in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0;
    in_branch_type = '0; in_jump = '0; in_pred_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",       {31'd0, in_ready},       32'd0);
    chk("rst_out_valid",      {31'd0, out_valid},      32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_flush",          {31'd0, flush},          32'd0);
    chk("rst_out_target",     out_target,     32'd0);
    chk("rst_cnt_branch",     cnt_branch,     32'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // beq equal, predicted not-taken: mispredict with redirect and flush
    run_txn(32'h8000_0000, 32'h10, 32'd5, 32'd5, 3'b001, 2'b00, 1'b0, 0, 0);
    chk("beq_taken",  {31'd0, obs_taken}, 32'd1);
    chk("beq_target", obs_target, 32'h8000_0010);
    chk("beq_flush",  flush_seen, 32'd1);
    chk("beq_cnt_misp", cnt_mispredict, 32'd1);

    // blt -1 < 1 signed, predicted taken: no redirect
    run_txn(32'h1000, 32'h40, 32'hFFFF_FFFF, 32'd1, 3'b011, 2'b00, 1'b1, 0, 0);
    chk("blt_taken", {31'd0, obs_taken}, 32'd1);
    chk("blt_flush", flush_seen, 32'd0);
    // bltu same operands: not taken, falls through, redirect
    run_txn(32'h1000, 32'h40, 32'hFFFF_FFFF, 32'd1, 3'b101, 2'b00, 1'b1, 0, 1);
    chk("bltu_taken",  {31'd0, obs_taken}, 32'd0);
    chk("bltu_target", obs_target, 32'h1004);

    // bge equality counts; bgeu 3 >= 0xFFFFFFFF is false
    run_txn(32'h2000, 32'h20, 32'd7, 32'd7, 3'b100, 2'b00, 1'b1, 1, 0);
    chk("bge_taken", {31'd0, obs_taken}, 32'd1);
    run_txn(32'h2000, 32'h20, 32'd3, 32'hFFFF_FFFF, 3'b110, 2'b00, 1'b0, 0, 0);
    chk("bgeu_taken", {31'd0, obs_taken}, 32'd0);
    chk("bgeu_target", obs_target, 32'h2004);

    // bne both directions
    run_txn(32'h3000, 32'hFFFF_FFF0, 32'd1, 32'd2, 3'b010, 2'b00, 1'b1, 0, 0);
    chk("bne_target", obs_target, 32'h2FF0);
    run_txn(32'h3000, 32'h8, 32'd9, 32'd9, 3'b010, 2'b00, 1'b1, 2, 0);

    // jalr clears bit 0
    run_txn(32'h8000_0000, 32'h4, 32'h8000_0103, 32'd0, 3'b000, 2'b10, 1'b0, 0, 0);
    chk("jalr_target", obs_target, 32'h8000_0106);
    chk("jalr_link",   obs_link,   32'h8000_0004);

    // jal, undefined branch types, jump=11 behaves as a branch
    run_txn(32'h4000, 32'h100, 32'd0, 32'd0, 3'b000, 2'b01, 1'b1, 0, 0);
    chk("jal_target", obs_target, 32'h4100);
    run_txn(32'h5000, 32'h100, 32'd4, 32'd4, 3'b000, 2'b00, 1'b1, 0, 0);
    chk("bt000_target", obs_target, 32'h5004);
    run_txn(32'h5000, 32'h100, 32'd4, 32'd4, 3'b111, 2'b00, 1'b0, 0, 0);
    run_txn(32'h6000, 32'h30, 32'd4, 32'd4, 3'b001, 2'b11, 1'b0, 0, 0);
    chk("jump11_target", obs_target, 32'h6030);

    // out_ready held off 3 cycles while the redirect completes first
    run_txn(32'h7000, 32'h10, 32'd1, 32'd1, 3'b001, 2'b00, 1'b0, 3, 0);
    // redirect held off after the result has gone
    run_txn(32'h7000, 32'h10, 32'd1, 32'd2, 3'b001, 2'b00, 1'b1, 0, 3);
    chk("cnt_branch_total", cnt_branch, 32'd14);

    // Reset while RESP has a pending redirect
    out_ready = 1'b0; redirect_ready = 1'b0;
    accept_txn(32'h9000, 32'h10, 32'd3, 32'd3, 3'b001, 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_front());
    exp_cnt_branch = 0;
    exp_cnt_misp   = 0;
    #1;
    chk("midrst_out_valid",      {31'd0, out_valid},      32'd0);
    chk("midrst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("midrst_flush",          {31'd0, flush},          32'd0);
    chk("midrst_cnt_branch",     cnt_branch,     32'd0);
    chk("midrst_cnt_misp",       cnt_mispredict, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);

    // Taken branch whose target wraps past 2^32
    run_txn(32'hFFFF_FFF8, 32'h10, 32'd8, 32'd8, 3'b001, 2'b00, 1'b1, 0, 0);
    chk("wrap_target", obs_target, 32'h0000_0008);
    chk("wrap_link",   obs_link,   32'hFFFF_FFFC);
    chk("wrap_cnt_branch", cnt_branch, 32'd1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
